qed_inst_sequencer: RTL and testbench
=====================================

Name: qed_inst_sequencer

Overview:
- Sequences the preloaded QED workload FIFO into the core's instruction-injection port for EDDI-V style self-checking.
- Pops each workload instruction and issues it twice: first the original, then a duplicate whose register fields are remapped to the shadow register half.
- Reports completion and a matching original/duplicate issue count to the QED consistency checker.

Parameters:
- INST_WIDTH, 32, instruction width; must match the workload FIFO data width.
- PTR_WIDTH, 5, workload FIFO pointer width; sets counter width to PTR_WIDTH+1.
- REG_OFFSET, 16, added to architectural register indices 1..15 to form the shadow index.

Ports:
- clk  in  1  single clock.
- rstn  in  1  reset, asynchronous, active-low.
- enable  in  1  start/continue issuing; sampled only in IDLE/FETCH.
- fifo_rd  out  1  pop strobe to the workload FIFO.
- fifo_rdata  in  INST_WIDTH  head instruction (combinational FIFO read).
- fifo_empty  in  1  FIFO exhausted.
- inst_out  out  INST_WIDTH  instruction to the core.
- inst_valid  out  1  inst_out valid.
- inst_ready  in  1  core accepts inst_out.
- inst_is_dup  out  1  high when inst_out is the duplicate.
- orig_cnt  out  PTR_WIDTH+1  originals accepted.
- dup_cnt  out  PTR_WIDTH+1  duplicates accepted.
- done  out  1  sticky; workload fully issued.
- qed_match  out  1  done && orig_cnt==dup_cnt.
- reg_err  out  1  sticky; an original used a register in 16..31.

Behaviour:
- Reset (async, rstn=0): state IDLE; inst_out=0, inst_valid=0, inst_is_dup=0, counters=0, done=0, reg_err=0, fifo_rd=0. Reset mid-handshake aborts the handshake immediately; no pop is issued.
- States: IDLE, ORIG, DUP, FETCH, DONE.
- IDLE/FETCH, enable=1, fifo_empty=0: register inst_out<=fifo_rdata, inst_valid<=1, inst_is_dup<=0, go to ORIG. Set reg_err if any used field of fifo_rdata is in 16..31.
- IDLE/FETCH, fifo_empty=1: go to DONE; done<=1. This check takes priority over enable.
- IDLE/FETCH, enable=0, fifo_empty=0: stay; inst_valid=0.
- ORIG: hold inst_out/inst_valid stable until inst_ready. On handshake: orig_cnt+1, inst_out<=remap(fifo_rdata) (FIFO not yet popped), inst_is_dup<=1, go to DUP; inst_valid stays 1.
- DUP: on handshake: dup_cnt+1, fifo_rd=1 combinationally that same cycle, inst_valid<=0, go to FETCH. fifo_rd is asserted only here.
- FETCH exists so fifo_empty/fifo_rdata reflect the pop. Steady throughput with inst_ready=1 is 2 instructions per 3 cycles.
- DONE: terminal until reset; inst_valid=0 (see optional feature).
- Counters saturate at all-ones; no wrap.
- enable deasserted during ORIG/DUP does not abort; the pair completes.
- Remap by opcode[6:0]. Fields: rd[11:7], rs1[19:15], rs2[24:20]. Field value 0 stays 0; values 1..15 get +REG_OFFSET; values ≥16 pass unchanged.
  - rd only: LUI 0110111, AUIPC 0010111, JAL 1101111.
  - rd+rs1: OP-IMM 0010011, OP-IMM-32 0011011, LOAD 0000011, JALR 1100111.
  - rd+rs1+rs2: OP 0110011, OP-32 0111011.
  - rs1+rs2: STORE 0100011, BRANCH 1100011.
  - Other opcodes: unchanged.

Optional Feature:
- QED_NOP_PAD_EN defined: in DONE, inst_valid=1 and inst_out=32'h00000013 (NOP) continuously, inst_is_dup=0. NOPs do not increment either counter.
- Not defined: in DONE, inst_valid=0 and inst_out holds its last value.

Decomposition:
- Package qed_pkg: opcode localparams, NOP constant, field bit positions, state enum typedef.
- One sub-module, qed_reg_remap: purely combinational. Inputs: instruction and REG_OFFSET. Outputs: remapped instruction and a high-register flag.

Test Plan:
- 32-entry FIFO, inst_ready=1, enable=1 from reset → 64 accepted instructions; orig_cnt=dup_cnt=32, done=1, qed_match=1, 32 fifo_rd pulses.
- Head 32'h00100093 (addi x1,x0,1) → original 32'h00100093, then duplicate 32'h00100893 (rd x17, rs1 x0 kept).
- Head 32'h020c9c93 (x25 source/dest) → duplicate equals original; reg_err=1 and stays set.
- inst_ready low for 5 cycles in ORIG → inst_out/inst_valid stable, no fifo_rd, orig_cnt unchanged until ready.
- Assert rstn=0 while in DUP with inst_valid=1 → inst_valid=0 asynchronously, counters 0, no fifo_rd pulse.
- With QED_NOP_PAD_EN, after final duplicate → inst_valid=1, inst_out=32'h00000013, counters frozen at 32.

Source files
------------

// File: rtl/qed_pkg.sv
// Shared constants for the QED instruction sequencer: RV opcodes, register-field
// positions, the NOP encoding and the sequencer state type.
package qed_pkg;

    localparam int OPC_W   = 7;
    localparam int REG_W   = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
    localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ORIG,
        ST_DUP,
        ST_FETCH,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/qed_inst_sequencer_if.sv
// Workload-FIFO read side and core instruction-injection handshake, as seen by
// the sequencer (master) and the FIFO/core pair (slave).
interface qed_inst_sequencer_if #(
    parameter int INST_WIDTH = 32
) ();

    logic                  fifo_rd;
    logic [INST_WIDTH-1:0] fifo_rdata;
    logic                  fifo_empty;
    logic [INST_WIDTH-1:0] inst_out;
    logic                  inst_valid;
    logic                  inst_ready;
    logic                  inst_is_dup;

    modport master (
        output fifo_rd, inst_out, inst_valid, inst_is_dup,
        input  fifo_rdata, fifo_empty, inst_ready
    );

    modport slave (
        input  fifo_rd, inst_out, inst_valid, inst_is_dup,
        output fifo_rdata, fifo_empty, inst_ready
    );

endinterface

// File: rtl/qed_reg_remap.sv
// Combinational EDDI-V register remap: moves the used register fields of an
// instruction into the shadow register half and flags use of the high half.
module qed_reg_remap
    import qed_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int REG_OFFSET = 16
) (
    input  logic [INST_WIDTH-1:0] inst,
    output logic [INST_WIDTH-1:0] inst_remap,
    output logic                  hi_reg
);

    logic use_rd, use_rs1, use_rs2;

    // x0 stays x0; registers already in the high half are left alone
    function automatic logic [REG_W-1:0] remap_field(input logic [REG_W-1:0] f);
        if (f == '0 || f[REG_W-1]) return f;
        return f + REG_W'(REG_OFFSET);
    endfunction

    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (inst[OPC_W-1:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL:                     use_rd = 1'b1;
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_OP, OPC_OP_32: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ;
        endcase

        inst_remap = inst;
        if (use_rd)  inst_remap[RD_LSB  +: REG_W] = remap_field(inst[RD_LSB  +: REG_W]);
        if (use_rs1) inst_remap[RS1_LSB +: REG_W] = remap_field(inst[RS1_LSB +: REG_W]);
        if (use_rs2) inst_remap[RS2_LSB +: REG_W] = remap_field(inst[RS2_LSB +: REG_W]);

        hi_reg = (use_rd  && inst[RD_LSB  + REG_W - 1]) ||
                 (use_rs1 && inst[RS1_LSB + REG_W - 1]) ||
                 (use_rs2 && inst[RS2_LSB + REG_W - 1]);
    end

endmodule

// File: rtl/qed_inst_sequencer.sv
// Issues each QED workload instruction as an original followed by a shadow-register
// duplicate. Build option QED_NOP_PAD_EN: stream NOPs once the workload is exhausted.
module qed_inst_sequencer
    import qed_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int PTR_WIDTH  = 5,
    parameter int REG_OFFSET = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    qed_inst_sequencer_if.master   bus,
    output logic [PTR_WIDTH:0]     orig_cnt,
    output logic [PTR_WIDTH:0]     dup_cnt,
    output logic                   done,
    output logic                   qed_match,
    output logic                   reg_err
);

    seq_state_t            state, state_nxt;
    logic [INST_WIDTH-1:0] inst_q, inst_nxt, remap_inst;
    logic                  valid_q, valid_nxt, dup_q, dup_nxt;
    logic [PTR_WIDTH:0]    orig_nxt, dup_cnt_nxt;
    logic                  done_nxt, err_nxt, hi_reg;

    function automatic logic [PTR_WIDTH:0] sat_inc(input logic [PTR_WIDTH:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Remap reads the FIFO head directly: it is not popped until the duplicate is taken
    qed_reg_remap #(
        .INST_WIDTH (INST_WIDTH),
        .REG_OFFSET (REG_OFFSET)
    ) u_remap (
        .inst       (bus.fifo_rdata),
        .inst_remap (remap_inst),
        .hi_reg     (hi_reg)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_q   <= '0;
            valid_q  <= 1'b0;
            dup_q    <= 1'b0;
            orig_cnt <= '0;
            dup_cnt  <= '0;
            done     <= 1'b0;
            reg_err  <= 1'b0;
        end else begin
            inst_q   <= inst_nxt;
            valid_q  <= valid_nxt;
            dup_q    <= dup_nxt;
            orig_cnt <= orig_nxt;
            dup_cnt  <= dup_cnt_nxt;
            done     <= done_nxt;
            reg_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        inst_nxt    = inst_q;
        valid_nxt   = valid_q;
        dup_nxt     = dup_q;
        orig_nxt    = orig_cnt;
        dup_cnt_nxt = dup_cnt;
        done_nxt    = done;
        err_nxt     = reg_err;
        case (state)
            ST_IDLE, ST_FETCH: begin
                if (bus.fifo_empty) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
`ifdef QED_NOP_PAD_EN
                    inst_nxt  = INST_WIDTH'(NOP_INST);
                    valid_nxt = 1'b1;
                    dup_nxt   = 1'b0;
`else
                    valid_nxt = 1'b0;
`endif
                end else if (enable) begin
                    state_nxt = ST_ORIG;
                    inst_nxt  = bus.fifo_rdata;
                    valid_nxt = 1'b1;
                    dup_nxt   = 1'b0;
                    if (hi_reg) err_nxt = 1'b1;
                end else begin
                    valid_nxt = 1'b0;
                end
            end
            ST_ORIG: begin
                if (bus.inst_ready) begin
                    state_nxt = ST_DUP;
                    orig_nxt  = sat_inc(orig_cnt);
                    inst_nxt  = remap_inst;
                    dup_nxt   = 1'b1;
                end
            end
            ST_DUP: begin
                if (bus.inst_ready) begin
                    state_nxt   = ST_FETCH;
                    dup_cnt_nxt = sat_inc(dup_cnt);
                    valid_nxt   = 1'b0;
                end
            end
            ST_DONE: begin
`ifdef QED_NOP_PAD_EN
                inst_nxt  = INST_WIDTH'(NOP_INST);
                valid_nxt = 1'b1;
                dup_nxt   = 1'b0;
`else
                valid_nxt = 1'b0;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.fifo_rd     = (state == ST_DUP) && bus.inst_ready;
    assign bus.inst_out    = inst_q;
    assign bus.inst_valid  = valid_q;
    assign bus.inst_is_dup = dup_q;
    assign qed_match       = done && (orig_cnt == dup_cnt);

endmodule

// File: tb/tb_qed_inst_sequencer.sv
// Directed bench for qed_inst_sequencer: remap vector table, stall, enable gating,
// reset during a duplicate, and a full 32-entry workload. Honours QED_NOP_PAD_EN.
module tb_qed_inst_sequencer;
    import qed_pkg::*;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] dup;
        logic        hi;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl[NV];

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        enable = 1'b0;
    logic [5:0]  orig_cnt, dup_cnt;
    logic        done, qed_match, reg_err;

    logic [31:0] mem[32];
    int          cnt_fifo = 0;
    int          rd_ptr = 0;
    int          pops = 0;
    logic        ptr_clr = 1'b0;
    logic [31:0] got_q[$];
    logic        got_dup_q[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qed_inst_sequencer_if #(.INST_WIDTH(32)) bus();

    assign bus.fifo_rdata = (rd_ptr < cnt_fifo) ? mem[rd_ptr[4:0]] : 32'h0;
    assign bus.fifo_empty = (rd_ptr >= cnt_fifo);

    qed_inst_sequencer #(
        .INST_WIDTH (32),
        .PTR_WIDTH  (5),
        .REG_OFFSET (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .bus       (bus),
        .orig_cnt  (orig_cnt),
        .dup_cnt   (dup_cnt),
        .done      (done),
        .qed_match (qed_match),
        .reg_err   (reg_err)
    );

    always @(posedge clk) begin
        if (ptr_clr)         rd_ptr <= 0;
        else if (bus.fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    // Handshakes and pops observed mid-cycle, ahead of the edge that takes them
    always @(negedge clk) begin
        if (ptr_clr) begin
            pops <= 0;
            got_q.delete();
            got_dup_q.delete();
        end else begin
            if (bus.fifo_rd) pops <= pops + 1;
            if (rstn && bus.inst_valid && bus.inst_ready && !done) begin
                got_q.push_back(bus.inst_out);
                got_dup_q.push_back(bus.inst_is_dup);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds reset, loads n workload entries starting at table index base
    task automatic load_fifo(input int n, input int base);
        rstn = 1'b0;
        enable = 1'b0;
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = (i < n) ? tbl[(base + i) % NV].inst : 32'h0;
        cnt_fifo = n;
        ptr_clr = 1'b1;
        repeat (2) step();
        ptr_clr = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done; i++) step();
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h00100093, 32'h00100893, 1'b0}; // addi x1,x0,1
        tbl[1] = '{32'h002081B3, 32'h012889B3, 1'b0}; // add x3,x1,x2
        tbl[2] = '{32'h00512423, 32'h01592423, 1'b0}; // sw x5,8(x2)
        tbl[3] = '{32'h12345537, 32'h12345D37, 1'b0}; // lui x10
        tbl[4] = '{32'h000280E7, 32'h000A88E7, 1'b0}; // jalr x1,0(x5)
        tbl[5] = '{32'h0051811B, 32'h0059891B, 1'b0}; // addiw x2,x3,5
        tbl[6] = '{32'h300110F3, 32'h300110F3, 1'b0}; // csrrw: not remapped
        tbl[7] = '{NOP_INST,     NOP_INST,     1'b0}; // addi x0,x0,0
        tbl[8] = '{32'h020c9c93, 32'h020c9c93, 1'b1}; // x25 src/dst
        tbl[9] = '{32'h01F00063, 32'h01F00063, 1'b1}; // beq x0,x31

        bus.inst_ready = 1'b0;
        #2;
        // ---- reset values, enable gating, ORIG stall ----
        load_fifo(2, 0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_out", bus.inst_out, 32'h0);
        chk("rst_dup", 32'(bus.inst_is_dup), 32'd0);
        chk("rst_orig", 32'(orig_cnt), 32'd0);
        chk("rst_dupcnt", 32'(dup_cnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(reg_err), 32'd0);
        chk("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        chk("rst_match", 32'(qed_match), 32'd0);
        rstn = 1'b1;
        repeat (3) step();
        chk("idle_valid", 32'(bus.inst_valid), 32'd0);
        enable = 1'b1;
        step();
        chk("orig_out", bus.inst_out, 32'h00100093);
        chk("orig_valid", 32'(bus.inst_valid), 32'd1);
        chk("orig_isdup", 32'(bus.inst_is_dup), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_out", bus.inst_out, 32'h00100093);
            chk("stall_valid", 32'(bus.inst_valid), 32'd1);
            chk("stall_orig", 32'(orig_cnt), 32'd0);
            chk("stall_pops", 32'(pops), 32'd0);
        end
        bus.inst_ready = 1'b1;
        enable = 1'b0;
        step();
        chk("dup_out", bus.inst_out, 32'h00100893);
        chk("dup_isdup", 32'(bus.inst_is_dup), 32'd1);
        chk("dup_orig", 32'(orig_cnt), 32'd1);
        step();
        chk("fetch_pops", 32'(pops), 32'd1);
        chk("fetch_dupcnt", 32'(dup_cnt), 32'd1);
        chk("fetch_valid", 32'(bus.inst_valid), 32'd0);
        repeat (2) step();
        chk("hold_valid", 32'(bus.inst_valid), 32'd0);
        chk("hold_orig", 32'(orig_cnt), 32'd1);
        enable = 1'b1;
        step();
        chk("second_out", bus.inst_out, 32'h002081B3);
        wait_done("done_a", 50);
        step();
        chk("a_orig", 32'(orig_cnt), 32'd2);
        chk("a_dup", 32'(dup_cnt), 32'd2);
        chk("a_match", 32'(qed_match), 32'd1);
        chk("a_err", 32'(reg_err), 32'd0);
        chk("a_pops", 32'(pops), 32'd2);
`ifdef QED_NOP_PAD_EN
        chk("a_nop_valid", 32'(bus.inst_valid), 32'd1);
        chk("a_nop_out", bus.inst_out, NOP_INST);
`else
        chk("a_end_valid", 32'(bus.inst_valid), 32'd0);
        chk("a_end_out", bus.inst_out, 32'h012889B3);
`endif

        // ---- reset while the duplicate is being offered ----
        load_fifo(2, 0);
        rstn = 1'b1;
        enable = 1'b1;
        step();
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        step();
        chk("c_in_dup", 32'(bus.inst_is_dup), 32'd1);
        chk("c_valid", 32'(bus.inst_valid), 32'd1);
        #2;
        rstn = 1'b0;
        bus.inst_ready = 1'b1;
        #1;
        chk("c_rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("c_rst_orig", 32'(orig_cnt), 32'd0);
        chk("c_rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        step();
        chk("c_pops", 32'(pops), 32'd0);
        chk("c_ptr", 32'(rd_ptr), 32'd0);

        // ---- full 32-entry workload through the vector table ----
        load_fifo(32, 0);
        enable = 1'b1;
        bus.inst_ready = 1'b1;
        rstn = 1'b1;
        wait_done("done_b", 400);
        step();
        chk("b_orig", 32'(orig_cnt), 32'd32);
        chk("b_dup", 32'(dup_cnt), 32'd32);
        chk("b_match", 32'(qed_match), 32'd1);
        chk("b_pops", 32'(pops), 32'd32);
        chk("b_err", 32'(reg_err), 32'd1);
        chk("b_accepted", 32'(got_q.size()), 32'd64);
        for (int k = 0; k < 64 && k < got_q.size(); k++) begin
            chk((k % 2) ? "b_dup_inst" : "b_orig_inst", got_q[k],
                (k % 2) ? tbl[(k / 2) % NV].dup : tbl[(k / 2) % NV].inst);
            chk("b_isdup", 32'(got_dup_q[k]), 32'(k % 2));
        end
`ifdef QED_NOP_PAD_EN
        repeat (3) step();
        chk("b_nop_valid", 32'(bus.inst_valid), 32'd1);
        chk("b_nop_out", bus.inst_out, NOP_INST);
        chk("b_nop_isdup", 32'(bus.inst_is_dup), 32'd0);
        chk("b_nop_orig", 32'(orig_cnt), 32'd32);
        chk("b_nop_dup", 32'(dup_cnt), 32'd32);
`else
        chk("b_end_valid", 32'(bus.inst_valid), 32'd0);
        chk("b_end_out", bus.inst_out, tbl[31 % NV].dup);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
